// File: rtl/float_div_iter.sv
// Iterative IEEE-754 single-precision divider: radix-2 restoring, one quotient
// bit per clock, one operation in flight, valid/ready stream handshake.
module float_div_iter #(
    parameter string EN_ROUND = "true"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] op_A,
    input  logic [31:0] op_B,
    input  logic        s_axi_last,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] op_result,
    output logic [1:0]  flow,
    output logic        div_zero,
    output logic        m_axi_last
);

    localparam bit RoundEn = (EN_ROUND == "true");

    typedef enum logic [1:0] {IDLE, CALC, PACK, DONE} state_t;
    typedef enum logic [2:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO, SP_DIVZ} class_t;

    state_t             state_q, state_d;
    class_t             cls_q, cls_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [25:0]        rem_q, rem_d;
    logic [24:0]        quo_q, quo_d;
    logic [23:0]        mantb_q, mantb_d;
    logic signed [9:0]  exp_q, exp_d;
    logic               sign_q, sign_d;
    logic               last_q, last_d;
    logic [31:0]        result_q, result_d;
    logic [1:0]         flow_q, flow_d;
    logic               divz_q, divz_d;
    logic               mlast_q, mlast_d;
    logic               valid_q, valid_d;

    logic [7:0]         ea, eb;
    logic [23:0]        ma, mb;
    logic               nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    class_t             cls_in;
    logic [25:0]        rem_sub;
    logic [23:0]        frac_sum;
    logic signed [9:0]  exp_r;

    assign ea     = op_A[30:23];
    assign eb     = op_B[30:23];
    assign ma     = {1'b1, op_A[22:0]};
    assign mb     = {1'b1, op_B[22:0]};
    assign nan_a  = (ea == 8'hFF) && (op_A[22:0] != '0);
    assign nan_b  = (eb == 8'hFF) && (op_B[22:0] != '0);
    assign inf_a  = (ea == 8'hFF) && (op_A[22:0] == '0);
    assign inf_b  = (eb == 8'hFF) && (op_B[22:0] == '0);
    assign zero_a = (ea == 8'h00);
    assign zero_b = (eb == 8'h00);

    always_comb begin
        cls_in = SP_NONE;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) cls_in = SP_NAN;
        else if (inf_a)  cls_in = SP_INF;
        else if (inf_b)  cls_in = SP_ZERO;
        else if (zero_b) cls_in = SP_DIVZ;
        else if (zero_a) cls_in = SP_ZERO;
    end

    assign rem_sub  = rem_q - {2'b00, mantb_q};
    assign frac_sum = {1'b0, quo_q[23:1]} + {23'd0, RoundEn & quo_q[0]};
    // A rounding carry out of the 23-bit fraction leaves frac_sum[22:0] at zero.
    assign exp_r    = exp_q + $signed({9'd0, frac_sum[23]});

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        mantb_d  = mantb_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        last_d   = last_q;
        result_d = result_q;
        flow_d   = flow_q;
        divz_d   = divz_q;
        mlast_d  = mlast_q;
        valid_d  = valid_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    sign_d  = op_A[31] ^ op_B[31];
                    cls_d   = cls_in;
                    mantb_d = mb;
                    last_d  = s_axi_last;
                    quo_d   = '0;
                    cnt_d   = '0;
                    if (ma < mb) begin
                        rem_d = {1'b0, ma, 1'b0};
                        exp_d = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd126;
                    end else begin
                        rem_d = {2'b00, ma};
                        exp_d = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
                    end
                    state_d = CALC;
                end
            end
            CALC: begin
                if (rem_q >= {2'b00, mantb_q}) begin
                    rem_d = {rem_sub[24:0], 1'b0};
                    quo_d = {quo_q[23:0], 1'b1};
                end else begin
                    rem_d = {rem_q[24:0], 1'b0};
                    quo_d = {quo_q[23:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd24) state_d = PACK;
            end
            PACK: begin
                flow_d  = 2'b00;
                divz_d  = 1'b0;
                mlast_d = last_q;
                valid_d = 1'b1;
                state_d = DONE;
                case (cls_q)
                    SP_NAN:  result_d = 32'h7FC0_0000;
                    SP_INF:  result_d = {sign_q, 8'hFF, 23'd0};
                    SP_ZERO: result_d = {sign_q, 31'd0};
                    SP_DIVZ: begin
                        result_d = {sign_q, 8'hFF, 23'd0};
                        divz_d   = 1'b1;
                    end
                    default: begin
                        if (exp_r >= 10'sd255) begin
                            result_d = {sign_q, 8'hFF, 23'd0};
                            flow_d   = 2'b10;
                        end else if (exp_r <= 10'sd0) begin
                            result_d = {sign_q, 31'd0};
                            flow_d   = 2'b01;
                        end else begin
                            result_d = {sign_q, exp_r[7:0], frac_sum[22:0]};
                        end
                    end
                endcase
            end
            DONE: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cls_q    <= SP_NONE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            mantb_q  <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            last_q   <= 1'b0;
            result_q <= '0;
            flow_q   <= '0;
            divz_q   <= 1'b0;
            mlast_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            mantb_q  <= mantb_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            last_q   <= last_d;
            result_q <= result_d;
            flow_q   <= flow_d;
            divz_q   <= divz_d;
            mlast_q  <= mlast_d;
            valid_q  <= valid_d;
        end
    end

    assign ready_o    = (state_q == IDLE);
    assign valid_o    = valid_q;
    assign op_result  = result_q;
    assign flow       = flow_q;
    assign div_zero   = divz_q;
    assign m_axi_last = mlast_q;

endmodule

// File: tb/tb_float_div_iter.sv
// Bench for float_div_iter: rounding and truncating instances side by side,
// checked against an integer-division reference model.
module tb_float_div_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b1;
    logic [31:0] op_A = '0;
    logic [31:0] op_B = '0;
    logic        s_axi_last = 1'b0;

    logic        ready_r, valid_r, div_zero_r, last_r;
    logic [31:0] res_r;
    logic [1:0]  flow_r;
    logic        ready_t, valid_t, div_zero_t, last_t;
    logic [31:0] res_t;
    logic [1:0]  flow_t;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    float_div_iter #(.EN_ROUND("true")) dut_r (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_r),
        .op_A(op_A), .op_B(op_B), .s_axi_last(s_axi_last),
        .valid_o(valid_r), .ready_i(ready_i), .op_result(res_r),
        .flow(flow_r), .div_zero(div_zero_r), .m_axi_last(last_r)
    );

    float_div_iter #(.EN_ROUND("false")) dut_t (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_t),
        .op_A(op_A), .op_B(op_B), .s_axi_last(s_axi_last),
        .valid_o(valid_t), .ready_i(ready_i), .op_result(res_t),
        .flow(flow_t), .div_zero(div_zero_t), .m_axi_last(last_t)
    );

    // Reference: quotient taken as an exact integer division of the scaled significands.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit rnd,
                                  output logic [31:0] r, output logic [1:0] fl, output logic dz);
        int     ea, eb, e;
        longint ma, mb, q, fr;
        bit     nan_a, nan_b, inf_a, inf_b, z_a, z_b;
        logic   s;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        nan_a = (ea == 255) && (a[22:0] != 0);
        nan_b = (eb == 255) && (b[22:0] != 0);
        inf_a = (ea == 255) && (a[22:0] == 0);
        inf_b = (eb == 255) && (b[22:0] == 0);
        z_a = (ea == 0);
        z_b = (eb == 0);
        s = a[31] ^ b[31];
        fl = 2'b00;
        dz = 1'b0;
        if (nan_a || nan_b || (z_a && z_b) || (inf_a && inf_b)) r = 32'h7FC00000;
        else if (inf_a) r = {s, 8'hFF, 23'd0};
        else if (inf_b) r = {s, 31'd0};
        else if (z_b) begin r = {s, 8'hFF, 23'd0}; dz = 1'b1; end
        else if (z_a) r = {s, 31'd0};
        else begin
            ma = longint'(a[22:0]) + 64'd8388608;
            mb = longint'(b[22:0]) + 64'd8388608;
            if (ma < mb) begin q = (ma << 25) / mb; e = ea - eb + 126; end
            else begin q = (ma << 24) / mb; e = ea - eb + 127; end
            fr = (q >> 1) & 64'h7FFFFF;
            if (rnd) fr = fr + (q & 1);
            if (fr == 64'h800000) begin fr = 0; e = e + 1; end
            if (e >= 255) begin r = {s, 8'hFF, 23'd0}; fl = 2'b10; end
            else if (e <= 0) begin r = {s, 31'd0}; fl = 2'b01; end
            else r = {s, e[7:0], fr[22:0]};
        end
    endfunction

    // Presents one operand pair and returns the accept-to-valid latency (-1 on timeout).
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic last, output int lat);
        int w;
        @(negedge clk);
        for (w = 0; w < 100 && !ready_r; w++) @(negedge clk);
        op_A = a; op_B = b; s_axi_last = last; valid_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (valid_r) begin lat = n; break; end
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (valid_r !== 1'b0 || ready_r !== 1'b1 || res_r !== 32'h0 || flow_r !== 2'b00 ||
            div_zero_r !== 1'b0 || last_r !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b ready=%b res=%h flow=%b dz=%b last=%b, required 0 1 0 00 0 0",
                     valid_r, ready_r, res_r, flow_r, div_zero_r, last_r);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_vector(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic last);
        int lat;
        logic [31:0] er, et;
        logic [1:0]  efr, eft;
        logic        edr, edt;
        model(a, b, 1'b1, er, efr, edr);
        model(a, b, 1'b0, et, eft, edt);
        issue(a, b, last, lat);
        checks++;
        if (lat !== 26 || valid_t !== 1'b1) begin
            errors++;
            $display("FAIL %s latency: got %0d (trunc valid=%b), required 26", name, lat, valid_t);
        end
        checks++;
        if (res_r !== er || flow_r !== efr || div_zero_r !== edr || last_r !== last) begin
            errors++;
            $display("FAIL %s round: res=%h flow=%b dz=%b last=%b, required %h %b %b %b",
                     name, res_r, flow_r, div_zero_r, last_r, er, efr, edr, last);
        end
        checks++;
        if (res_t !== et || flow_t !== eft || div_zero_t !== edt || last_t !== last) begin
            errors++;
            $display("FAIL %s trunc: res=%h flow=%b dz=%b last=%b, required %h %b %b %b",
                     name, res_t, flow_t, div_zero_t, last_t, et, eft, edt, last);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid_r !== 1'b0 || ready_r !== 1'b1) begin
            errors++;
            $display("FAIL %s handoff: valid=%b ready=%b, required 0 1", name, valid_r, ready_r);
        end
    endtask

    task automatic test_directed;
        logic [31:0] r;
        logic [1:0]  fl;
        logic        dz;
        test_vector("six_by_two", 32'h40C00000, 32'h40000000, 1'b1);
        checks++;
        if (res_r !== 32'h40400000) begin
            errors++;
            $display("FAIL six_by_two const: got %h, required 40400000", res_r);
        end
        test_vector("one_third", 32'h3F800000, 32'h40400000, 1'b0);
        checks++;
        if (res_r !== 32'h3EAAAAAB || res_t !== 32'h3EAAAAAA) begin
            errors++;
            $display("FAIL one_third const: got %h/%h, required 3EAAAAAB/3EAAAAAA", res_r, res_t);
        end
        test_vector("overflow", 32'h7F000000, 32'h3E800000, 1'b0);
        checks++;
        if (res_r !== 32'h7F800000 || flow_r !== 2'b10) begin
            errors++;
            $display("FAIL overflow const: got %h %b, required 7F800000 10", res_r, flow_r);
        end
        test_vector("underflow", 32'h00800000, 32'h4B000000, 1'b1);
        checks++;
        if (res_r !== 32'h00000000 || flow_r !== 2'b01) begin
            errors++;
            $display("FAIL underflow const: got %h %b, required 00000000 01", res_r, flow_r);
        end
        test_vector("div_by_zero", 32'h3F800000, 32'h80000000, 1'b0);
        checks++;
        if (res_r !== 32'hFF800000 || div_zero_r !== 1'b1) begin
            errors++;
            $display("FAIL div_by_zero const: got %h dz=%b, required FF800000 1", res_r, div_zero_r);
        end
        test_vector("zero_zero", 32'h00000000, 32'h00000000, 1'b0);
        test_vector("inf_by_two", 32'h7F800000, 32'h40000000, 1'b1);
        test_vector("two_by_neginf", 32'h40000000, 32'hFF800000, 1'b0);
        model(32'h00000000, 32'h00000000, 1'b1, r, fl, dz);
        checks++;
        if (res_r !== 32'h80000000 || r !== 32'h7FC00000) begin
            errors++;
            $display("FAIL special const: got %h model %h, required 80000000 7FC00000", res_r, r);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        logic [31:0] er, er2;
        logic [1:0]  efr;
        logic        edr;
        ready_i = 1'b0;
        model(32'h41200000, 32'h40A00000, 1'b1, er, efr, edr);
        issue(32'h41200000, 32'h40A00000, 1'b1, lat);
        checks++;
        if (lat !== 26) begin
            errors++;
            $display("FAIL bp latency: got %0d, required 26", lat);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (valid_r !== 1'b1 || ready_r !== 1'b0 || res_r !== er || last_r !== 1'b1) begin
                errors++;
                $display("FAIL bp hold %0d: valid=%b ready=%b res=%h last=%b, required 1 0 %h 1",
                         i, valid_r, ready_r, res_r, last_r, er);
            end
            op_A = $urandom; op_B = $urandom; valid_i = i[0];
        end
        @(negedge clk);
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (valid_r !== 1'b0 || ready_r !== 1'b1) begin
            errors++;
            $display("FAIL bp release: valid=%b ready=%b, required 0 1", valid_r, ready_r);
        end
        model(32'hC2C80000, 32'h41200000, 1'b1, er2, efr, edr);
        test_vector("bp_next", 32'hC2C80000, 32'h41200000, 1'b0);
        checks++;
        if (res_r !== 32'hC1200000 || er2 !== 32'hC1200000) begin
            errors++;
            $display("FAIL bp_next const: got %h, required C1200000", res_r);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        op_A = 32'h3F800000; op_B = 32'h40400000; s_axi_last = 1'b1; valid_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (valid_r !== 1'b0 || ready_r !== 1'b1 || res_r !== 32'h0 || last_r !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b ready=%b res=%h last=%b, required 0 1 0 0",
                     valid_r, ready_r, res_r, last_r);
        end
        @(negedge clk);
        rst = 1'b0;
        test_vector("after_reset", 32'h40C00000, 32'h40000000, 1'b0);
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic [7:0]  e;
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 2; k++) begin
                e = 8'($urandom_range(1, 254));
                if ($urandom_range(0, 9) == 0) e = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
                if (k == 0) a = {1'($urandom), e, 23'($urandom)};
                else        b = {1'($urandom), e, 23'($urandom)};
            end
            if (b[30:23] == 8'hFF && $urandom_range(0, 1) == 0) b[22:0] = '0;
            if (i < 10) b[30:23] = 8'(int'(a[30:23]) - 100 + 20 * i);
            test_vector("random", a, b, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
